// File: rtl/sdr_req_splitter.sv
// sdr_req_splitter: pops {wr, len, addr} entries from the upstream request
// FIFO and turns each into burst requests of at most MAX_BURST beats that
// never cross a 2^CW-word column page. Requests leave on a registered
// valid/ready interface.
// Optional statistics counters are built only when SDR_SPLIT_STATS_EN is
// defined; otherwise the stat ports are tied to zero.
module sdr_req_splitter #(
  parameter int AW        = 22,
  parameter int LW        = 6,
  parameter int CW        = 8,
  parameter int MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fifo_empty,
  input  logic [LW+AW:0]   fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [AW-1:0]    req_addr,
  output logic [LW-1:0]    req_len,
  output logic             req_wr,
  output logic             req_last,
  output logic [15:0]      stat_req_cnt,
  output logic [15:0]      stat_split_cnt,
  output logic [15:0]      stat_zero_cnt
);

  // Width wide enough to hold the page room (up to 2^CW) and any length.
  localparam int SW = ((LW > CW) ? LW : CW) + 2;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [AW-1:0]   r_addr;       // start address of the presented chunk
  logic [LW-1:0]   r_rem;        // beats left in the entry, incl. presented chunk
  logic [LW-1:0]   r_req_len;
  logic            r_req_valid;
  logic            r_req_wr;
  logic            r_req_last;

  logic            w_fifo_wr;
  logic [LW-1:0]   w_fifo_len;
  logic [AW-1:0]   w_fifo_addr;
  logic            w_hs;
  logic            w_pop;
  logic            w_load;
  logic            w_done;
  logic [AW-1:0]   w_src_addr;
  logic [LW-1:0]   w_src_rem;
  logic [SW-1:0]   w_room;
  logic [SW-1:0]   w_min_rb;
  logic [LW-1:0]   w_chunk;

  assign w_fifo_wr   = fifo_rd_data[LW+AW];
  assign w_fifo_len  = fifo_rd_data[LW+AW-1:AW];
  assign w_fifo_addr = fifo_rd_data[AW-1:0];

  assign w_hs = r_req_valid & req_ready;

  // The next chunk is cut either from a freshly popped entry (IDLE) or from
  // what is left after the presented chunk is accepted (ISSUE).
  assign w_src_addr = (r_state == S_IDLE) ? w_fifo_addr : r_addr + AW'(r_req_len);
  assign w_src_rem  = (r_state == S_IDLE) ? w_fifo_len  : r_rem - r_req_len;

  // Chunk = min(remaining, MAX_BURST, words left in the column page).
  assign w_room   = (SW'(1) << CW) - SW'(w_src_addr[CW-1:0]);
  assign w_min_rb = (SW'(w_src_rem) < SW'(MAX_BURST)) ? SW'(w_src_rem) : SW'(MAX_BURST);
  assign w_chunk  = LW'((w_room < w_min_rb) ? w_room : w_min_rb);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!fifo_empty) begin
          w_pop = 1'b1;
          if (w_fifo_len != '0) begin
            w_load      = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (w_hs) begin
          if (r_req_last) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign fifo_rd_en = w_pop;

  // Register each chunk as it is cut; hold it until accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_rem       <= '0;
      r_req_len   <= '0;
      r_req_valid <= 1'b0;
      r_req_wr    <= 1'b0;
      r_req_last  <= 1'b0;
    end else if (w_load) begin
      r_addr      <= w_src_addr;
      r_rem       <= w_src_rem;
      r_req_len   <= w_chunk;
      r_req_last  <= (w_chunk == w_src_rem);
      r_req_valid <= 1'b1;
      if (r_state == S_IDLE) r_req_wr <= w_fifo_wr;
    end else if (w_done) begin
      r_req_valid <= 1'b0;
    end
  end

  assign req_valid = r_req_valid;
  assign req_addr  = r_addr;
  assign req_len   = r_req_len;
  assign req_wr    = r_req_wr;
  assign req_last  = r_req_last;

`ifdef SDR_SPLIT_STATS_EN
  logic        w_split;
  logic        w_zero;
  logic [15:0] r_stat_req;
  logic [15:0] r_stat_split;
  logic [15:0] r_stat_zero;

  // A chunk is a split when the page term alone made it shorter.
  assign w_split = w_load & (w_room < w_min_rb);
  assign w_zero  = w_pop & (w_fifo_len == '0);

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_req   <= '0;
      r_stat_split <= '0;
      r_stat_zero  <= '0;
    end else begin
      if (w_hs    && r_stat_req   != 16'hFFFF) r_stat_req   <= r_stat_req + 16'd1;
      if (w_split && r_stat_split != 16'hFFFF) r_stat_split <= r_stat_split + 16'd1;
      if (w_zero  && r_stat_zero  != 16'hFFFF) r_stat_zero  <= r_stat_zero + 16'd1;
    end
  end

  assign stat_req_cnt   = r_stat_req;
  assign stat_split_cnt = r_stat_split;
  assign stat_zero_cnt  = r_stat_zero;
`else
  assign stat_req_cnt   = '0;
  assign stat_split_cnt = '0;
  assign stat_zero_cnt  = '0;
`endif

endmodule

// File: tb/tb_sdr_req_splitter.sv
// Testbench for sdr_req_splitter: a queue-backed FIFO model feeds entries,
// a reference model expands every pushed entry into its expected requests,
// and a negedge monitor compares each accepted request plus handshake rules.
module tb_sdr_req_splitter;

  localparam int AW = 22;
  localparam int LW = 6;
  localparam int CW = 8;
  localparam int MB = 8;
  localparam int DW = 1 + LW + AW;

`ifdef SDR_SPLIT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk;
  logic            reset_n;
  logic            fifo_empty;
  logic [DW-1:0]   fifo_rd_data;
  logic            fifo_rd_en;
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic [LW-1:0]   req_len;
  logic            req_wr;
  logic            req_last;
  logic [15:0]     stat_req_cnt;
  logic [15:0]     stat_split_cnt;
  logic [15:0]     stat_zero_cnt;

  sdr_req_splitter #(.AW(AW), .LW(LW), .CW(CW), .MAX_BURST(MB)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fifo_empty     (fifo_empty),
    .fifo_rd_data   (fifo_rd_data),
    .fifo_rd_en     (fifo_rd_en),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .req_wr         (req_wr),
    .req_last       (req_last),
    .stat_req_cnt   (stat_req_cnt),
    .stat_split_cnt (stat_split_cnt),
    .stat_zero_cnt  (stat_zero_cnt)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          wr;
    logic          last;
  } req_t;

  req_t          exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int            total = 0;
  int            bad = 0;
  int            exp_req = 0;
  int            exp_split = 0;
  int            exp_zero = 0;
  int            ready_ctl = 0;   // 0: always ready, 1: random, 2: held low

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur within its cycle budget (t=%0t)", name, $time);
  endtask

  task automatic update_fifo_if();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = fifo_empty ? '0 : fifo_q[0];
  endtask

  // Reference model: cut the entry into chunks straight from the rules.
  task automatic push_entry(input logic wr, input int len, input int addr);
    int rem;
    int a;
    fifo_q.push_back({wr, LW'(len), AW'(addr)});
    if (len == 0) begin
      exp_zero++;
    end else begin
      rem = len;
      a   = addr;
      while (rem > 0) begin
        int   room;
        int   lim;
        int   c;
        req_t r;
        room = (1 << CW) - (a % (1 << CW));
        lim  = (rem < MB) ? rem : MB;
        c    = (room < lim) ? room : lim;
        if (room < lim) exp_split++;
        r.addr = AW'(a);
        r.len  = LW'(c);
        r.wr   = wr;
        r.last = (c == rem);
        exp_q.push_back(r);
        exp_req++;
        rem = rem - c;
        a   = (a + c) % (1 << AW);
      end
    end
    update_fifo_if();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && !req_valid && !fifo_rd_en)) begin
      @(negedge clk);
      n++;
      if (n > 20000) begin
        fail_now(name);
        break;
      end
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_stat_req"},   32'(stat_req_cnt),   STATS ? 32'(exp_req)   : 32'd0);
    check({tag, "_stat_split"}, 32'(stat_split_cnt), STATS ? 32'(exp_split) : 32'd0);
    check({tag, "_stat_zero"},  32'(stat_zero_cnt),  STATS ? 32'(exp_zero)  : 32'd0);
  endtask

  // FIFO pop and ready driver: sample the pop strobe mid-cycle, act after the edge.
  initial begin
    logic pop_req;
    forever begin
      @(negedge clk);
      pop_req = fifo_rd_en && reset_n;
      @(posedge clk);
      #1;
      if (pop_req && fifo_q.size() > 0) void'(fifo_q.pop_front());
      update_fifo_if();
      case (ready_ctl)
        0:       req_ready = 1'b1;
        1:       req_ready = ($urandom_range(0, 2) != 0);
        default: req_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard compare on handshake plus per-cycle protocol rules.
  initial begin
    logic          p_valid, p_ready, p_hs, p_last, p_wr, p_pop_nz;
    logic [AW-1:0] p_addr;
    logic [LW-1:0] p_len;
    req_t          e;
    p_valid = 0; p_ready = 0; p_hs = 0; p_last = 0; p_wr = 0; p_pop_nz = 0;
    p_addr = '0; p_len = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        p_valid = 0; p_ready = 0; p_hs = 0; p_last = 0; p_pop_nz = 0;
      end else begin
        check("fifo_rd_en", 32'(fifo_rd_en), 32'(!req_valid && !fifo_empty));
        if (p_pop_nz) check("pop_to_valid", 32'(req_valid), 32'd1);
        if (p_hs)     check("valid_after_hs", 32'(req_valid), 32'(!p_last));
        if (p_valid && !p_ready) begin
          check("stall_valid", 32'(req_valid), 32'd1);
          check("stall_addr",  32'(req_addr),  32'(p_addr));
          check("stall_len",   32'(req_len),   32'(p_len));
          check("stall_wr",    32'(req_wr),    32'(p_wr));
          check("stall_last",  32'(req_last),  32'(p_last));
        end
        if (req_valid && req_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_req: got addr=0x%0h len=%0d, required no request", req_addr, req_len);
          end else begin
            e = exp_q.pop_front();
            check("req_addr", 32'(req_addr), 32'(e.addr));
            check("req_len",  32'(req_len),  32'(e.len));
            check("req_wr",   32'(req_wr),   32'(e.wr));
            check("req_last", 32'(req_last), 32'(e.last));
          end
        end
        p_pop_nz = fifo_rd_en && (fifo_rd_data[LW+AW-1:AW] != '0);
        p_valid  = req_valid;
        p_ready  = req_ready;
        p_hs     = req_valid && req_ready;
        p_addr   = req_addr;
        p_len    = req_len;
        p_wr     = req_wr;
        p_last   = req_last;
      end
    end
  end

  // Stimulus.
  initial begin
    int            n;
    logic [AW-1:0] ra;
    int            rl;
    reset_n      = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;
    req_ready    = 1'b0;
    #3;
    check("rst_valid",  32'(req_valid),  32'd0);
    check("rst_rd_en",  32'(fifo_rd_en), 32'd0);
    check("rst_addr",   32'(req_addr),   32'd0);
    check("rst_len",    32'(req_len),    32'd0);
    check("rst_wr",     32'(req_wr),     32'd0);
    check("rst_last",   32'(req_last),   32'd0);
    check_stats("rst");
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;

    // Single short write entry.
    step();
    push_entry(1'b1, 4, 'h10);
    drain("t1_drain");
    check_stats("t1");

    // Length-limited splitting.
    step();
    push_entry(1'b0, 20, 'h0);
    drain("t2_drain");
    check_stats("t2");

    // Page crossing.
    step();
    push_entry(1'b0, 6, 'hFE);
    drain("t3_drain");
    check_stats("t3");

    // Backpressure on the first chunk with more entries waiting.
    ready_ctl = 2;
    step();
    push_entry(1'b1, 16, 'h200);
    push_entry(1'b0, 3, 'h400);
    n = 0;
    while (!req_valid) begin
      @(negedge clk);
      n++;
      if (n > 20) begin fail_now("t4_wait_valid"); break; end
    end
    repeat (5) begin
      @(negedge clk);
      check("bp_rd_en", 32'(fifo_rd_en), 32'd0);
      check("bp_valid", 32'(req_valid),  32'd1);
      check("bp_addr",  32'(req_addr),   32'h200);
    end
    ready_ctl = 0;
    drain("t4_drain");
    check_stats("t4");

    // Zero-length entry followed by a single beat at the top address.
    step();
    push_entry(1'b0, 0, 'h123);
    push_entry(1'b1, 1, 'h3FFFFF);
    drain("t5_drain");
    check_stats("t5");

    // Randomized entries with random backpressure.
    ready_ctl = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      ra = AW'($urandom);
      if ($urandom_range(0, 1) != 0) ra[7:0] = 8'hF0 | 8'($urandom_range(0, 15));
      rl = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 63));
      push_entry(1'($urandom_range(0, 1)), rl, int'(ra));
      repeat ($urandom_range(0, 3)) step();
    end
    drain("rand_drain");
    check_stats("rand");

    // Asynchronous reset during the second chunk.
    ready_ctl = 0;
    step();
    push_entry(1'b1, 20, 'h1000);
    n = 0;
    while (!(req_valid && req_addr == AW'('h1008))) begin
      @(negedge clk);
      n++;
      if (n > 50) begin fail_now("t7_wait_chunk2"); break; end
    end
    #1 reset_n = 1'b0;
    #1;
    check("midrst_valid", 32'(req_valid), 32'd0);
    check("midrst_addr",  32'(req_addr),  32'd0);
    check("midrst_len",   32'(req_len),   32'd0);
    check("midrst_last",  32'(req_last),  32'd0);
    exp_q.delete();
    fifo_q.delete();
    exp_req   = 0;
    exp_split = 0;
    exp_zero  = 0;
    update_fifo_if();
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    end
    check_stats("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdr_req_splitter.md
Name: sdr_req_splitter

Overview:
- Consumes command entries from the upstream request sync FIFO and splits each one into SDRAM-legal burst requests for the downstream bank/command scheduler.
- Each entry carries {wr_flag, length, start address}.
- Requests are limited to MAX_BURST beats and never cross a column page boundary.
- Output uses a valid/ready handshake with registered outputs.

Parameters:
- AW, 22, word address width
- LW, 6, entry length field width; length in beats, 0 to 2^LW-1
- CW, 8, column address bits; page size = 2^CW words
- MAX_BURST, 8, maximum beats per output request; power of 2, at most 2^CW and at most 2^LW-1

Ports:
- clk, input, 1, clock
- reset_n, input, 1, asynchronous active-low reset
- fifo_empty, input, 1, upstream FIFO empty flag
- fifo_rd_data, input, 1+LW+AW, entry {wr[LW+AW], len[LW+AW-1:AW], addr[AW-1:0]}; combinational, valid whenever fifo_empty=0
- fifo_rd_en, output, 1, pop strobe
- req_valid, output, 1, request valid
- req_ready, input, 1, downstream accepts request
- req_addr, output, AW, burst start word address
- req_len, output, LW, burst beats, 1 to MAX_BURST
- req_wr, output, 1, 1 = write, 0 = read
- req_last, output, 1, final chunk of the current entry
- stat_req_cnt, output, 16, requests issued (see Optional Feature)
- stat_split_cnt, output, 16, page-boundary splits
- stat_zero_cnt, output, 16, zero-length entries dropped

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk.
  - State = IDLE.
  - fifo_rd_en=0, req_valid=0, req_addr=0, req_len=0, req_wr=0, req_last=0.
  - Internal remaining count and address = 0; stat counters = 0.
- fifo_rd_en is combinational: 1 only when state=IDLE and fifo_empty=0. It is never asserted when empty and is a single-cycle strobe per entry.
- IDLE:
  - On pop, the entry is captured in the same cycle.
  - len=0: entry discarded, no request, remain in IDLE (next pop possible next cycle).
  - len>0: compute first chunk, register req_* outputs, req_valid=1 next cycle, go to ISSUE.
  - Latency: pop at cycle N gives req_valid at N+1.
- Chunk size = min(remaining, MAX_BURST, 2^CW - addr[CW-1:0]).
  - req_last=1 when chunk == remaining.
  - A chunk limited by the page term (strictly smaller than min(remaining, MAX_BURST)) counts as one split.
- ISSUE:
  - req_* outputs are held stable while req_valid=1 and req_ready=0.
  - No FIFO pop while in ISSUE.
  - On handshake (req_valid & req_ready) with req_last=0: addr += chunk (modulo 2^AW), remaining -= chunk. Next chunk is registered and presented the following cycle with req_valid continuously high (no bubble).
  - On handshake with req_last=1: req_valid=0 next cycle, go to IDLE.
  - Back-to-back entries therefore have exactly one idle cycle between the last handshake and the next req_valid.
- Address wrap at 2^AW is silent. The page boundary check uses addr[CW-1:0] only.
- Reset asserted mid-burst: in-flight entry and remaining chunks are lost; all outputs return to reset values immediately (async).
- req_ready is ignored while req_valid=0.
- All arithmetic is unsigned. remaining is LW bits; chunk fits in LW bits.

Optional Feature:
- SDR_SPLIT_STATS_EN defined:
  - stat_req_cnt increments on each handshake.
  - stat_split_cnt increments on each page-limited chunk when it is registered.
  - stat_zero_cnt increments on each len=0 pop.
  - All counters saturate at 0xFFFF and clear only on reset.
- Not defined: the three stat ports are tied to 0, no counter flops are inferred, and functional behaviour is otherwise identical.

Test Plan:
- Single entry {wr=1, len=4, addr=0x000010}, req_ready=1:
  - fifo_rd_en one cycle.
  - Next cycle: one request addr=0x10, len=4, wr=1, last=1.
  - req_valid low the cycle after.
- Entry {wr=0, len=20, addr=0x000000}, MAX_BURST=8, ready=1:
  - Requests 8@0x00, 8@0x08, 4@0x10 on consecutive cycles.
  - last=1 only on the third; stat_split_cnt=0.
- Page crossing, CW=8, entry {len=6, addr=0x0000FE}:
  - Requests 2@0x0FE (last=0), then 4@0x100 (last=1).
  - stat_split_cnt=1 (with macro).
- Backpressure: req_ready=0 for 5 cycles during the first chunk of a len=16 entry, FIFO non-empty:
  - req_addr, req_len, req_last stable and req_valid held high.
  - fifo_rd_en stays 0.
  - Second chunk appears only the cycle after ready rises.
- Entries len=0 then {len=1, addr=0x3FFFFF}:
  - First is popped with no request.
  - Second yields 1@0x3FFFFF, last=1.
  - With macro: stat_zero_cnt=1, stat_req_cnt=1.
- Mid-burst reset: assert reset_n=0 during the second chunk of a len=20 entry:
  - req_valid=0 immediately.
  - After release with fifo_empty=1: fifo_rd_en never asserts and all stat counters read 0.
